// File: rtl/block_lock_ctrl.sv
// Block-lock controller for a 20->66 receive gearbox: hunts for sync-header
// alignment by requesting slips, then monitors header quality per window.
module block_lock_ctrl #(
  parameter int LOCK_CNT  = 64,
  parameter int WIN       = 64,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic        sh_valid,
  input  logic [1:0]  sh,
  output logic        slip,
  output logic        block_lock,
  output logic [15:0] slip_count
);

  localparam int GMAX = (LOCK_CNT > WIN) ? LOCK_CNT : WIN;
  localparam int GW   = $clog2(GMAX + 1);
  localparam int BW   = $clog2(BAD_MAX + 1);
  localparam int WW   = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] LOCK_C = GW'(LOCK_CNT);
  localparam logic [GW-1:0] WIN_C  = GW'(WIN);
  localparam logic [BW-1:0] BAD_C  = BW'(BAD_MAX);
  localparam logic [WW-1:0] WAIT_C = WW'(SLIP_WAIT);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_HUNT   = 3'd1,
    ST_LOCKED = 3'd2,
    ST_SLIP   = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   good_cnt_q, good_cnt_d;
  logic [BW-1:0]   bad_cnt_q, bad_cnt_d;
  logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            slip_q, slip_d;
  logic            lock_q, lock_d;
  logic [15:0]     slip_count_q, slip_count_d;

  logic [GW-1:0]   good_inc;
  logic [BW-1:0]   bad_inc;
  logic [WW-1:0]   wait_inc;
  logic            hdr_ok;

  function automatic logic hdr_good(input logic [1:0] h);
    return (h == 2'b01) || (h == 2'b10);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hdr_ok   = hdr_good(sh);
  assign good_inc = good_cnt_q + GW'(1);
  assign bad_inc  = bad_cnt_q + BW'(!hdr_ok);
  assign wait_inc = wait_cnt_q + WW'(1);

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    slip_d       = slip_q;
    lock_d       = lock_q;
    slip_count_d = slip_count_q;

    if (!enable) begin
      state_d    = ST_INIT;
      slip_d     = 1'b0;
      lock_d     = 1'b0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          wait_cnt_d = '0;
          state_d    = ST_HUNT;
        end

        ST_HUNT: begin
          lock_d = 1'b0;
          if (sh_valid) begin
            if (!hdr_ok) begin
              slip_d  = 1'b1;
              state_d = ST_SLIP;
            end else if (good_inc == LOCK_C) begin
              lock_d     = 1'b1;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
              state_d    = ST_LOCKED;
            end else begin
              good_cnt_d = good_inc;
            end
          end
        end

        // A bad header that exhausts the budget wins over the window boundary.
        ST_LOCKED: begin
          if (sh_valid) begin
            if (!hdr_ok && (bad_inc == BAD_C)) begin
              lock_d     = 1'b0;
              slip_d     = 1'b1;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
              state_d    = ST_SLIP;
            end else if (good_inc == WIN_C) begin
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_inc;
              bad_cnt_d  = bad_inc;
            end
          end
        end

        ST_SLIP: begin
          slip_d = 1'b1;
          if (sh_valid) begin
            slip_d       = 1'b0;
            slip_count_d = sat_inc16(slip_count_q);
            wait_cnt_d   = '0;
            state_d      = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (sh_valid) begin
            if (wait_inc == WAIT_C) begin
              wait_cnt_d = '0;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
              state_d    = ST_HUNT;
            end else begin
              wait_cnt_d = wait_inc;
            end
          end
        end

        default: begin
          state_d    = ST_INIT;
          slip_d     = 1'b0;
          lock_d     = 1'b0;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_INIT;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      slip_q       <= 1'b0;
      lock_q       <= 1'b0;
      slip_count_q <= '0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      slip_q       <= slip_d;
      lock_q       <= lock_d;
      slip_count_q <= slip_count_d;
    end
  end

  assign slip       = slip_q;
  assign block_lock = lock_q;
  assign slip_count = slip_count_q;

endmodule

// File: tb/tb_block_lock_ctrl.sv
// Directed bench for block_lock_ctrl: lock acquisition, slips, window
// monitoring, enable/reset handling and slip_count saturation.
module tb_block_lock_ctrl;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sh_valid = 1'b0;
  logic [1:0]  sh = 2'b01;
  logic        slip;
  logic        block_lock;
  logic [15:0] slip_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  block_lock_ctrl #(
    .LOCK_CNT (64),
    .WIN      (64),
    .BAD_MAX  (16),
    .SLIP_WAIT(4)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .enable    (enable),
    .sh_valid  (sh_valid),
    .sh        (sh),
    .slip      (slip),
    .block_lock(block_lock),
    .slip_count(slip_count)
  );

  // One valid word, presented between edges and sampled 1 time unit after the edge.
  task automatic send(input logic [1:0] h);
    sh_valid = 1'b1;
    sh       = h;
    @(posedge clk);
    #1;
    sh_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    #12;
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL reset_slip: got %b want 0", slip); end
    n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", block_lock); end
    n_tests++; if (slip_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %h want 0000", slip_count); end
    @(negedge clk);
    arst_n = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lock;
    int slip_seen;
    slip_seen = 0;
    for (int i = 1; i <= 64; i++) begin
      idle(i % 3);
      send(2'b01);
      if (slip !== 1'b0) slip_seen++;
      if (i == 63) begin
        n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0", block_lock); end
      end
    end
    n_tests++; if (block_lock !== 1'b1) begin n_fail++; $display("FAIL lock_64: got %b want 1", block_lock); end
    n_tests++; if (slip_seen !== 0) begin n_fail++; $display("FAIL lock_noslip: slip seen %0d times want 0", slip_seen); end
    idle(2);
    n_tests++; if (block_lock !== 1'b1) begin n_fail++; $display("FAIL lock_hold: got %b want 1", block_lock); end
  endtask

  task automatic test_window;
    int slip_seen;
    for (int i = 1; i <= 64; i++) send((i <= 15) ? 2'b00 : 2'b10);
    n_tests++; if (block_lock !== 1'b1) begin n_fail++; $display("FAIL win15_lock: got %b want 1", block_lock); end
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL win15_slip: got %b want 0", slip); end
    for (int i = 1; i <= 15; i++) send(2'b00);
    n_tests++; if (block_lock !== 1'b1) begin n_fail++; $display("FAIL win2_15_lock: got %b want 1", block_lock); end
    send(2'b00);
    n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL win16_lock: got %b want 0", block_lock); end
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL win16_slip: got %b want 1", slip); end
    idle(3);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL slip_held: got %b want 1", slip); end
    send(2'b11);
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL slip_exit: got %b want 0", slip); end
    n_tests++; if (slip_count !== 16'd1) begin n_fail++; $display("FAIL count_1: got %0d want 1", slip_count); end
    slip_seen = 0;
    for (int i = 0; i < 4; i++) begin
      send(2'b11);
      if (slip !== 1'b0) slip_seen++;
    end
    n_tests++; if (slip_seen !== 0) begin n_fail++; $display("FAIL wait_ignored: slip seen %0d times want 0", slip_seen); end
    send(2'b00);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL wait_5th_checked: got %b want 1", slip); end
    send(2'b01);
    n_tests++; if (slip_count !== 16'd2) begin n_fail++; $display("FAIL count_2: got %0d want 2", slip_count); end
    for (int i = 0; i < 4; i++) send(2'b01);
  endtask

  task automatic test_hunt_slip;
    int slip_seen;
    for (int i = 0; i < 9; i++) send(2'b01);
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL hunt9_slip: got %b want 0", slip); end
    send(2'b11);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL hunt10_slip: got %b want 1", slip); end
    idle(2);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL hunt_slip_held: got %b want 1", slip); end
    send(2'b01);
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL hunt_slip_exit: got %b want 0", slip); end
    n_tests++; if (slip_count !== 16'd3) begin n_fail++; $display("FAIL count_3: got %0d want 3", slip_count); end
    slip_seen = 0;
    for (int i = 0; i < 4; i++) begin
      send(2'b11);
      if (slip !== 1'b0) slip_seen++;
    end
    n_tests++; if (slip_seen !== 0) begin n_fail++; $display("FAIL hunt_wait_ignored: slip seen %0d times want 0", slip_seen); end
    for (int i = 1; i <= 64; i++) begin
      send(2'b10);
      if (i == 63) begin
        n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b want 0", block_lock); end
      end
    end
    n_tests++; if (block_lock !== 1'b1) begin n_fail++; $display("FAIL relock_64: got %b want 1", block_lock); end
  endtask

  task automatic test_bad_priority;
    for (int i = 0; i < 48; i++) send(2'b10);
    for (int i = 0; i < 15; i++) send(2'b00);
    n_tests++; if (block_lock !== 1'b1) begin n_fail++; $display("FAIL prio63_lock: got %b want 1", block_lock); end
    send(2'b00);
    n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL prio64_lock: got %b want 0", block_lock); end
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL prio64_slip: got %b want 1", slip); end
    send(2'b01);
    n_tests++; if (slip_count !== 16'd4) begin n_fail++; $display("FAIL count_4: got %0d want 4", slip_count); end
    send(2'b01);
    send(2'b01);
    enable = 1'b0;
    idle(1);
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL dis_slip: got %b want 0", slip); end
    n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL dis_lock: got %b want 0", block_lock); end
    n_tests++; if (slip_count !== 16'd4) begin n_fail++; $display("FAIL dis_count_held: got %0d want 4", slip_count); end
    send(2'b00);
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL dis_init_hold: got %b want 0", slip); end
    enable = 1'b1;
    idle(1);
    send(2'b00);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL reenable_hunt: got %b want 1", slip); end
    send(2'b01);
    n_tests++; if (slip_count !== 16'd5) begin n_fail++; $display("FAIL count_5: got %0d want 5", slip_count); end
    for (int i = 0; i < 4; i++) send(2'b01);
  endtask

  task automatic test_saturate;
    force dut.slip_count_q = 16'hFFFF;
    idle(1);
    release dut.slip_count_q;
    idle(1);
    n_tests++; if (slip_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preset: got %h want ffff", slip_count); end
    send(2'b11);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL sat_slip: got %b want 1", slip); end
    send(2'b01);
    n_tests++; if (slip_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", slip_count); end
    for (int i = 0; i < 4; i++) send(2'b01);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 64; i++) send(2'b01);
    n_tests++; if (block_lock !== 1'b1) begin n_fail++; $display("FAIL ar_locked: got %b want 1", block_lock); end
    send(2'b00);
    #2;
    arst_n = 1'b0;
    #1;
    n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL ar_lock_now: got %b want 0", block_lock); end
    n_tests++; if (slip_count !== 16'd0) begin n_fail++; $display("FAIL ar_count_now: got %h want 0000", slip_count); end
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'b11);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL ar_preslip: got %b want 1", slip); end
    #2;
    arst_n = 1'b0;
    #1;
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL ar_slip_now: got %b want 0", slip); end
    n_tests++; if (block_lock !== 1'b0) begin n_fail++; $display("FAIL ar_lock2_now: got %b want 0", block_lock); end
    @(negedge clk);
    arst_n = 1'b1;
    send(2'b11);
    n_tests++; if (slip !== 1'b0) begin n_fail++; $display("FAIL ar_init_edge: got %b want 0", slip); end
    send(2'b11);
    n_tests++; if (slip !== 1'b1) begin n_fail++; $display("FAIL ar_hunt_edge2: got %b want 1", slip); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_window();
    test_hunt_slip();
    test_bad_priority();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, want completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
